// File: rtl/tile_game_pkg.sv
// tile_game_pkg
// Shared types and helpers for the tile memory-game controller.
//   state_e              controller state encoding
//   COL_BASE / COL_FLASH colour-mode values driven on draw_flash_o
//   clog2_min1()         bits needed to index n items (never less than 1)
//   max_int()            larger of two integers
//   at_least_one()       clamps a cycle count so that 0 behaves as 1
package tile_game_pkg;

  typedef enum logic [3:0] {
    INIT,
    IDLE,
    ROUND,
    PB_FLASH,
    PB_HOLD,
    PB_RESTORE,
    PB_GAP,
    PL_WAIT,
    PL_FLASH,
    PL_HOLD,
    PL_RESTORE,
    PL_NEXT,
    DONE
  } state_e;

  localparam logic COL_BASE  = 1'b0;
  localparam logic COL_FLASH = 1'b1;

  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int at_least_one(input int n);
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/tile_painter.sv
// tile_painter
// Sweeps one tile's pixels: after a start pulse, plot_o is high for exactly
// TILE_PIXELS consecutive cycles while pixel_idx_o counts 0..TILE_PIXELS-1.
// done_o pulses during the last plotted pixel.
// Ports:
//   clock, resetn   system clock, synchronous active-low reset
//   start_i         one-cycle request; ignored while a pass is running
//   plot_o          pixel write enable
//   pixel_idx_o     pixel index within the tile
//   done_o          high on the final pixel of the pass
module tile_painter
  import tile_game_pkg::*;
#(
  parameter int TILE_PIXELS = 64
) (
  input  logic                                clock,
  input  logic                                resetn,
  input  logic                                start_i,
  output logic                                plot_o,
  output logic [clog2_min1(TILE_PIXELS)-1:0]  pixel_idx_o,
  output logic                                done_o
);

  localparam int PW = clog2_min1(TILE_PIXELS);
  localparam logic [PW-1:0] LAST_PIX = PW'(TILE_PIXELS - 1);

  logic          busy_q;
  logic [PW-1:0] idx_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      busy_q <= 1'b0;
      idx_q  <= '0;
    end else if (busy_q) begin
      if (idx_q == LAST_PIX) begin
        busy_q <= 1'b0;
        idx_q  <= '0;
      end else begin
        idx_q <= idx_q + PW'(1);
      end
    end else if (start_i) begin
      busy_q <= 1'b1;
      idx_q  <= '0;
    end
  end

  assign plot_o      = busy_q;
  assign pixel_idx_o = idx_q;
  assign done_o      = busy_q && (idx_q == LAST_PIX);

endmodule

// File: rtl/tile_game_ctrl.sv
// tile_game_ctrl
// Memory-game controller: grows a random tile sequence one tile per round,
// plays it back as flash/restore paint passes, echoes and checks each player
// press, and reports score and win/lose.
// Optional feature: define TILE_GAME_TIMEOUT_EN to make the player lose after
// TIMEOUT_CYCLES without a press; otherwise the controller waits forever.
// Ports:
//   clock, resetn    system clock, synchronous active-low reset
//   start_i          begins a game (accepted only in IDLE/DONE)
//   target_len_i     rounds needed to win, sampled on accepted start
//   rnd_i            random tile, sampled once per round
//   btn_valid_i      player press strobe, btn_tile_i is the pressed tile
//   plot_o           pixel write enable, pixel_idx_o pixel within tile
//   draw_tile_o      tile being painted, draw_flash_o highlight/base colour
//   player_turn_o    waiting for a press
//   score_o          completed rounds; win_o / lose_o game outcome
module tile_game_ctrl
  import tile_game_pkg::*;
#(
  parameter int NUM_TILES      = 4,
  parameter int TILE_PIXELS    = 64,
  parameter int MAX_LEN        = 16,
  parameter int FLASH_CYCLES   = 25000000,
  parameter int GAP_CYCLES     = 12500000,
  parameter int TIMEOUT_CYCLES = 250000000
) (
  input  logic                                 clock,
  input  logic                                 resetn,
  input  logic                                 start_i,
  input  logic [clog2_min1(MAX_LEN + 1)-1:0]   target_len_i,
  input  logic [clog2_min1(NUM_TILES)-1:0]     rnd_i,
  input  logic                                 btn_valid_i,
  input  logic [clog2_min1(NUM_TILES)-1:0]     btn_tile_i,
  output logic                                 plot_o,
  output logic [clog2_min1(TILE_PIXELS)-1:0]   pixel_idx_o,
  output logic [clog2_min1(NUM_TILES)-1:0]     draw_tile_o,
  output logic                                 draw_flash_o,
  output logic                                 player_turn_o,
  output logic [clog2_min1(MAX_LEN + 1)-1:0]   score_o,
  output logic                                 win_o,
  output logic                                 lose_o
);

  localparam int TW = clog2_min1(NUM_TILES);
  localparam int LW = clog2_min1(MAX_LEN + 1);
  localparam int SW = clog2_min1(MAX_LEN);
`ifdef TILE_GAME_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  // One shared delay counter, wide enough for the longest wait in use.
  localparam int CW = clog2_min1(max_int(
      max_int(at_least_one(FLASH_CYCLES), at_least_one(GAP_CYCLES)),
      TIMEOUT_EN ? at_least_one(TIMEOUT_CYCLES) : 1));
  localparam logic [CW-1:0] FLASH_LAST = CW'(at_least_one(FLASH_CYCLES) - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(at_least_one(GAP_CYCLES) - 1);
`ifdef TILE_GAME_TIMEOUT_EN
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(at_least_one(TIMEOUT_CYCLES) - 1);
`endif

  state_e        state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [LW-1:0] round_len_q, round_len_d;
  logic [LW-1:0] target_q, target_d;
  logic [LW-1:0] score_q, score_d;
  logic          win_q, win_d, lose_q, lose_d;
  logic [TW-1:0] pressed_q, pressed_d;
  logic [TW-1:0] draw_tile_q, draw_tile_d;
  logic          draw_flash_q, draw_flash_d;
  logic          kick_q, kick_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] seq_q [MAX_LEN];
  logic          seq_we;
  logic [SW-1:0] seq_waddr;
  logic [SW-1:0] last_step;
  logic          paint_done;

  // kick_q is a one-cycle start strobe to the painter, registered so the
  // tile/colour registers are already settled the cycle before plot rises.
  tile_painter #(
    .TILE_PIXELS(TILE_PIXELS)
  ) u_painter (
    .clock      (clock),
    .resetn     (resetn),
    .start_i    (kick_q),
    .plot_o     (plot_o),
    .pixel_idx_o(pixel_idx_o),
    .done_o     (paint_done)
  );

  assign last_step = SW'(round_len_q - LW'(1));
  assign seq_waddr = SW'(round_len_q - LW'(1));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= INIT;
      step_q       <= '0;
      round_len_q  <= LW'(1);
      target_q     <= LW'(1);
      score_q      <= '0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
      pressed_q    <= '0;
      draw_tile_q  <= '0;
      draw_flash_q <= COL_BASE;
      // INIT starts painting tile 0 straight out of reset.
      kick_q       <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      round_len_q  <= round_len_d;
      target_q     <= target_d;
      score_q      <= score_d;
      win_q        <= win_d;
      lose_q       <= lose_d;
      pressed_q    <= pressed_d;
      draw_tile_q  <= draw_tile_d;
      draw_flash_q <= draw_flash_d;
      kick_q       <= kick_d;
      cnt_q        <= cnt_d;
    end
  end

  // Sequence memory is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (seq_we) seq_q[seq_waddr] <= rnd_i;
  end

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    round_len_d  = round_len_q;
    target_d     = target_q;
    score_d      = score_q;
    win_d        = win_q;
    lose_d       = lose_q;
    pressed_d    = pressed_q;
    draw_tile_d  = draw_tile_q;
    draw_flash_d = draw_flash_q;
    kick_d       = 1'b0;
    cnt_d        = cnt_q + CW'(1);
    seq_we       = 1'b0;

    case (state_q)
      INIT: begin
        if (paint_done) begin
          if (draw_tile_q == TW'(NUM_TILES - 1)) begin
            draw_tile_d = '0;
            state_d     = IDLE;
          end else begin
            draw_tile_d = draw_tile_q + TW'(1);
            kick_d      = 1'b1;
          end
        end
      end
      IDLE, DONE: begin
        if (start_i) begin
          if (target_len_i == '0) target_d = LW'(1);
          else if (int'(target_len_i) > MAX_LEN) target_d = LW'(MAX_LEN);
          else target_d = target_len_i;
          score_d     = '0;
          win_d       = 1'b0;
          lose_d      = 1'b0;
          round_len_d = LW'(1);
          state_d     = ROUND;
        end
      end
      ROUND: begin
        seq_we       = 1'b1;
        step_d       = '0;
        // In round 1 seq[0] is being written this very cycle, so bypass it.
        draw_tile_d  = (round_len_q == LW'(1)) ? rnd_i : seq_q[0];
        draw_flash_d = COL_FLASH;
        kick_d       = 1'b1;
        state_d      = PB_FLASH;
      end
      PB_FLASH: begin
        cnt_d = '0;
        if (paint_done) state_d = PB_HOLD;
      end
      PB_HOLD: begin
        if (cnt_q == FLASH_LAST) begin
          draw_flash_d = COL_BASE;
          kick_d       = 1'b1;
          state_d      = PB_RESTORE;
        end
      end
      PB_RESTORE: begin
        cnt_d = '0;
        if (paint_done) state_d = PB_GAP;
      end
      PB_GAP: begin
        if (cnt_q == GAP_LAST) begin
          if (step_q == last_step) begin
            step_d  = '0;
            cnt_d   = '0;
            state_d = PL_WAIT;
          end else begin
            step_d       = step_q + SW'(1);
            draw_tile_d  = seq_q[step_q + SW'(1)];
            draw_flash_d = COL_FLASH;
            kick_d       = 1'b1;
            state_d      = PB_FLASH;
          end
        end
      end
      PL_WAIT: begin
        if (btn_valid_i) begin
          pressed_d    = btn_tile_i;
          draw_tile_d  = btn_tile_i;
          draw_flash_d = COL_FLASH;
          kick_d       = 1'b1;
          state_d      = PL_FLASH;
        end
`ifdef TILE_GAME_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          lose_d  = 1'b1;
          state_d = DONE;
        end
`endif
      end
      PL_FLASH: begin
        cnt_d = '0;
        if (paint_done) state_d = PL_HOLD;
      end
      PL_HOLD: begin
        if (cnt_q == FLASH_LAST) begin
          draw_flash_d = COL_BASE;
          kick_d       = 1'b1;
          state_d      = PL_RESTORE;
        end
      end
      PL_RESTORE: begin
        if (paint_done) state_d = PL_NEXT;
      end
      PL_NEXT: begin
        if ((int'(pressed_q) >= NUM_TILES) || (pressed_q != seq_q[step_q])) begin
          lose_d  = 1'b1;
          state_d = DONE;
        end else if (step_q != last_step) begin
          step_d  = step_q + SW'(1);
          cnt_d   = '0;
          state_d = PL_WAIT;
        end else begin
          score_d = round_len_q;
          if (round_len_q == target_q) begin
            win_d   = 1'b1;
            state_d = DONE;
          end else begin
            round_len_d = round_len_q + LW'(1);
            state_d     = ROUND;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign draw_tile_o   = draw_tile_q;
  assign draw_flash_o  = draw_flash_q;
  assign player_turn_o = (state_q == PL_WAIT);
  assign score_o       = score_q;
  assign win_o         = win_q;
  assign lose_o        = lose_q;

endmodule

// File: tb/tb_tile_game_ctrl.sv
// tb_tile_game_ctrl
// Scoreboard bench for tile_game_ctrl (4 tiles, 4 pixels, flash 2, gap 1,
// max length 8). Stimulus pushes the expected paint passes, turn starts and
// game results into a queue; a monitor pops and compares them as the DUT
// shows them. Define TILE_GAME_TIMEOUT_EN to also cover the player timeout.
module tb_tile_game_ctrl;

  localparam int NT = 4;
  localparam int TP = 4;
  localparam int ML = 8;
  localparam int FC = 2;
  localparam int GC = 1;
  localparam int TC = 10;

  localparam int K_PAINT  = 0;
  localparam int K_TURN   = 1;
  localparam int K_RESULT = 2;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [3:0] target_len = '0;
  logic [1:0] rnd = '0;
  logic       btn_valid = 1'b0;
  logic [1:0] btn_tile = '0;
  logic       plot;
  logic [1:0] pixel_idx;
  logic [1:0] draw_tile;
  logic       draw_flash;
  logic       player_turn;
  logic [3:0] score;
  logic       win;
  logic       lose;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int kind;
    int a;
    int b;
    int c;
  } exp_t;

  exp_t expQ[$];
  int   gameSeq[8];

  tile_game_ctrl #(
    .NUM_TILES     (NT),
    .TILE_PIXELS   (TP),
    .MAX_LEN       (ML),
    .FLASH_CYCLES  (FC),
    .GAP_CYCLES    (GC),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .start_i      (start),
    .target_len_i (target_len),
    .rnd_i        (rnd),
    .btn_valid_i  (btn_valid),
    .btn_tile_i   (btn_tile),
    .plot_o       (plot),
    .pixel_idx_o  (pixel_idx),
    .draw_tile_o  (draw_tile),
    .draw_flash_o (draw_flash),
    .player_turn_o(player_turn),
    .score_o      (score),
    .win_o        (win),
    .lose_o       (lose)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic pushExp(input int kind, input int a, input int b, input int c);
    exp_t e;
    e.kind = kind;
    e.a = a;
    e.b = b;
    e.c = c;
    expQ.push_back(e);
  endtask

  // A shown tile is always a flash pass followed by a restore pass.
  task automatic pushShow(input int tile);
    pushExp(K_PAINT, tile, 1, 0);
    pushExp(K_PAINT, tile, 0, 0);
  endtask

  task automatic pushInit();
    for (int t = 0; t < NT; t++) pushExp(K_PAINT, t, 0, 0);
  endtask

  // ---------------- monitor ----------------
  logic plotPrev = 1'b0, turnPrev = 1'b0, donePrev = 1'b0;
  int   tilePrev = 0, flashPrev = 0, plotLen = 0, curTile = 0, curFlash = 0;

  task automatic popExpect(input int kind, output exp_t e, output bit ok);
    ok = 1'b0;
    e.kind = -1; e.a = 0; e.b = 0; e.c = 0;
    if (expQ.size() == 0) begin
      checkOutput("unexpected event kind", kind, -1);
    end else begin
      e = expQ.pop_front();
      checkOutput("event kind", kind, e.kind);
      ok = (kind == e.kind);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    bit   ok;
    if (plot && !plotPrev) begin
      popExpect(K_PAINT, e, ok);
      curTile  = e.a;
      curFlash = e.b;
      plotLen  = 0;
      if (ok) begin
        checkOutput("paint setup tile", tilePrev, e.a);
        checkOutput("paint setup flash", flashPrev, e.b);
      end
    end
    if (plot) begin
      checkOutput("pixel_idx", int'(pixel_idx), plotLen);
      checkOutput("paint tile", int'(draw_tile), curTile);
      checkOutput("paint flash", int'(draw_flash), curFlash);
      plotLen++;
    end
    if (!plot && plotPrev) checkOutput("plot length", plotLen, TP);
    if (player_turn && !turnPrev) begin
      popExpect(K_TURN, e, ok);
      if (ok) checkOutput("score at turn", int'(score), e.a);
    end
    if ((win || lose) && !donePrev) begin
      popExpect(K_RESULT, e, ok);
      if (ok) begin
        checkOutput("result score", int'(score), e.a);
        checkOutput("result win", int'(win), e.b);
        checkOutput("result lose", int'(lose), e.c);
      end
    end
    plotPrev  = plot;
    turnPrev  = player_turn;
    donePrev  = win || lose;
    tilePrev  = int'(draw_tile);
    flashPrev = int'(draw_flash);
  end

  // ---------------- stimulus helpers ----------------
  task automatic waitIdle(input string name);
    int n = 0;
    while ((expQ.size() != 0 || plot) && n < 600) begin
      @(negedge clock);
      n++;
    end
    checkOutput({"pending events after ", name}, expQ.size(), 0);
    expQ.delete();
  endtask

  task automatic checkIdle();
    checkOutput("idle plot", int'(plot), 0);
    checkOutput("idle pixel_idx", int'(pixel_idx), 0);
    checkOutput("idle draw_tile", int'(draw_tile), 0);
    checkOutput("idle draw_flash", int'(draw_flash), 0);
    checkOutput("idle player_turn", int'(player_turn), 0);
    checkOutput("idle score", int'(score), 0);
    checkOutput("idle win", int'(win), 0);
    checkOutput("idle lose", int'(lose), 0);
  endtask

  task automatic pulseStart(input int target);
    target_len = target[3:0];
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic pressTile(input int tile, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!player_turn && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (!player_turn) begin
      checkOutput("player_turn wait", 0, 1);
      return;
    end
    btn_tile  = tile[1:0];
    btn_valid = 1'b1;
    @(negedge clock);
    btn_valid = 1'b0;
    checkOutput("player_turn drop", int'(player_turn), 0);
    ok = 1'b1;
  endtask

  // Plays one game on gameSeq. A nonzero failRound makes the last press of
  // that round failTile instead of the sequence value.
  task automatic applyStimulus(input int target, input int failRound, input int failTile,
                               input bit noise);
    int  effT;
    int  tile;
    bit  lost;
    bit  ok;
    effT = (target == 0) ? 1 : ((target > ML) ? ML : target);

    lost = 1'b0;
    for (int r = 1; r <= effT && !lost; r++) begin
      for (int s = 0; s < r; s++) pushShow(gameSeq[s]);
      for (int s = 0; s < r && !lost; s++) begin
        pushExp(K_TURN, r - 1, 0, 0);
        tile = (r == failRound && s == r - 1) ? failTile : gameSeq[s];
        pushShow(tile);
        if (tile != gameSeq[s]) begin
          pushExp(K_RESULT, r - 1, 0, 1);
          lost = 1'b1;
        end
      end
      if (!lost && r == effT) pushExp(K_RESULT, r, 1, 0);
    end

    rnd = gameSeq[0][1:0];
    pulseStart(target);
    if (noise) begin
      repeat (2) @(negedge clock);
      btn_tile  = 2'd2;
      btn_valid = 1'b1;
      @(negedge clock);
      btn_valid = 1'b0;
      pulseStart(1);
    end

    lost = 1'b0;
    ok   = 1'b1;
    for (int r = 1; r <= effT && !lost && ok; r++) begin
      for (int s = 0; s < r && !lost && ok; s++) begin
        tile = (r == failRound && s == r - 1) ? failTile : gameSeq[s];
        pressTile(tile, ok);
        if (tile != gameSeq[s]) lost = 1'b1;
      end
      if (r < 8) rnd = gameSeq[r][1:0];
      if (noise && !lost) begin
        @(negedge clock);
        btn_tile  = 2'd0;
        btn_valid = 1'b1;
        @(negedge clock);
        btn_valid = 1'b0;
        pulseStart(1);
      end
    end
    waitIdle("game");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    $display("[TB] tile_game_ctrl bench start");

    resetn = 1'b0;
    pushInit();
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    waitIdle("init");
    checkIdle();

    gameSeq = '{3, 1, 0, 0, 0, 0, 0, 0};
    applyStimulus(2, 0, 0, 1'b1);

    gameSeq = '{3, 1, 2, 0, 0, 0, 0, 0};
    applyStimulus(3, 2, 0, 1'b0);

    gameSeq = '{2, 0, 0, 0, 0, 0, 0, 0};
    applyStimulus(0, 0, 0, 1'b0);

    gameSeq = '{0, 1, 2, 3, 3, 2, 1, 0};
    applyStimulus(15, 0, 0, 1'b0);

    // Reset while the first playback tile is being held.
    rnd = 2'd1;
    pushExp(K_PAINT, 1, 1, 0);
    pulseStart(1);
    n = 0;
    while (!plot && n < 50) begin @(negedge clock); n++; end
    while (plot && n < 100) begin @(negedge clock); n++; end
    checkOutput("reached hold before reset", int'(plot), 0);
    resetn = 1'b0;
    pushInit();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    waitIdle("mid-hold reset");
    checkIdle();

`ifdef TILE_GAME_TIMEOUT_EN
    rnd = 2'd2;
    pushShow(2);
    pushExp(K_TURN, 0, 0, 0);
    pushExp(K_RESULT, 0, 0, 1);
    pulseStart(1);
    n = 0;
    while (!player_turn && n < 100) begin @(negedge clock); n++; end
    n = 0;
    while (!lose && n < 50) begin @(negedge clock); n++; end
    checkOutput("timeout latency", n, TC);
    waitIdle("timeout");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
